// File: rtl/keypad_digit_display_if.sv
// Keypad-side inputs and display-side outputs of the keypad digit display.
// The master drives key code, key level and clear; the slave drives the display.
interface keypad_digit_display_if;
    logic [3:0] key_code;
    logic       key_pressed;
    logic       clr;
    logic [7:0] an;
    logic [7:0] seg;
    logic [3:0] digit_count;
    logic       key_event;

    modport master (
        output key_code,
        output key_pressed,
        output clr,
        input  an,
        input  seg,
        input  digit_count,
        input  key_event
    );

    modport slave (
        input  key_code,
        input  key_pressed,
        input  clr,
        output an,
        output seg,
        output digit_count,
        output key_event
    );
endinterface

// File: rtl/keypad_digit_display.sv
// Eight-digit hex entry field: shifts each new key press into a digit buffer
// and time-multiplexes the buffer onto a common-anode 7-segment display.
module keypad_digit_display #(
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    keypad_digit_display_if.slave kp
);

    localparam int                CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [3:0]        FULL     = 4'd8;

    function automatic logic [7:0] hex7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Unlit positions are fully dark; lit ones keep dp off (bit 7 set in hex7).
    function automatic logic [7:0] digit_seg(input logic [3:0] d, input logic lit);
        return lit ? hex7(d) : 8'hFF;
    endfunction

    logic             key_q;
    logic             press_evt;
    logic             accept;
    logic [31:0]      buffer;
    logic [3:0]       digit_count_r;
    logic             key_event_r;

    logic [CNT_W-1:0] refresh_cnt;
    logic [2:0]       scan_idx_p0;
    logic [3:0]       cur_digit;
    logic             cur_lit;
    logic [7:0]       an_p1;
    logic [7:0]       seg_p1;

    assign press_evt = kp.key_pressed & ~key_q;
    assign accept    = press_evt & ~kp.clr;

    // Entry stage: edge detect, shift buffer, occupancy count.
    // key_q resets high so a key held through reset release is not an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q         <= 1'b1;
            buffer        <= 32'd0;
            digit_count_r <= 4'd0;
            key_event_r   <= 1'b0;
        end else begin
            key_q       <= kp.key_pressed;
            key_event_r <= accept;
            if (kp.clr) begin
                buffer        <= 32'd0;
                digit_count_r <= 4'd0;
            end else if (press_evt) begin
                buffer <= {buffer[27:0], kp.key_code};
                if (digit_count_r != FULL) begin
                    digit_count_r <= digit_count_r + 4'd1;
                end
            end
        end
    end

    // Scan stage: refresh divider and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            scan_idx_p0 <= 3'd0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            scan_idx_p0 <= scan_idx_p0 + 3'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign cur_digit = buffer[{scan_idx_p0, 2'b00} +: 4];
    assign cur_lit   = BLANK_LEADING ? ({1'b0, scan_idx_p0} < digit_count_r) : 1'b1;

    // Drive stage: registered anodes and cathodes, one cycle behind the index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_p1  <= 8'hFF;
            seg_p1 <= 8'hFF;
        end else begin
            an_p1  <= ~(8'd1 << scan_idx_p0);
            seg_p1 <= digit_seg(cur_digit, cur_lit);
        end
    end

    assign kp.an          = an_p1;
    assign kp.seg         = seg_p1;
    assign kp.digit_count = digit_count_r;
    assign kp.key_event   = key_event_r;

endmodule

// File: tb/tb_keypad_digit_display.sv
// Directed bench for keypad_digit_display: two instances (blanking on/off)
// share the same keypad stimulus with REFRESH_DIV = 4.
module tb_keypad_digit_display;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] hex7_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    keypad_digit_display_if kb0();
    keypad_digit_display_if kb1();

    assign kb1.key_code    = kb0.key_code;
    assign kb1.key_pressed = kb0.key_pressed;
    assign kb1.clr         = kb0.clr;

    keypad_digit_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kb0.slave)
    );

    keypad_digit_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kb1.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic press_start(input logic [3:0] code);
        @(negedge clk);
        kb0.key_code    = code;
        kb0.key_pressed = 1'b1;
        @(negedge clk);
    endtask

    task automatic release_key();
        kb0.key_pressed = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_an(input logic [7:0] target, output bit found);
        found = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (kb0.an === target) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        kb0.key_pressed = 1'b1;
        kb0.key_code    = 4'h6;
        kb0.clr         = 1'b0;
        rst_n           = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (kb0.an !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h expected ff", kb0.an); end
        checks++; if (kb0.seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h expected ff", kb0.seg); end
        checks++; if (kb0.digit_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", kb0.digit_count); end
        checks++; if (kb0.key_event !== 1'b0) begin errors++; $display("FAIL reset_event: got %b expected 0", kb0.key_event); end
        checks++; if (kb1.seg !== 8'hFF) begin errors++; $display("FAIL reset_seg_noblank: got %h expected ff", kb1.seg); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (kb0.an !== 8'hFE) begin errors++; $display("FAIL reset_first_an: got %h expected fe", kb0.an); end
        for (int k = 0; k < 6; k++) begin
            checks++; if (kb0.key_event !== 1'b0) begin errors++; $display("FAIL reset_held_event: cycle %0d got %b expected 0", k, kb0.key_event); end
            @(negedge clk);
        end
        checks++; if (kb0.digit_count !== 4'd0) begin errors++; $display("FAIL reset_held_count: got %0d expected 0", kb0.digit_count); end
        release_key();
    endtask

    task automatic test_single_entry();
        bit         found;
        logic [7:0] exp_an;
        press_start(4'h5);
        checks++; if (kb0.key_event !== 1'b1) begin errors++; $display("FAIL single_event: got %b expected 1", kb0.key_event); end
        checks++; if (kb0.digit_count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", kb0.digit_count); end
        @(negedge clk);
        checks++; if (kb0.key_event !== 1'b0) begin errors++; $display("FAIL single_event_width: got %b expected 0", kb0.key_event); end
        release_key();
        for (int i = 0; i < 8; i++) begin
            exp_an = ~(8'd1 << i);
            wait_an(exp_an, found);
            checks++; if (!found) begin errors++; $display("FAIL single_scan_timeout: an %h never seen", exp_an); end
            checks++; if (kb0.seg !== ((i == 0) ? 8'h92 : 8'hFF)) begin errors++; $display("FAIL single_seg: digit %0d got %h expected %h", i, kb0.seg, (i == 0) ? 8'h92 : 8'hFF); end
            checks++; if (kb1.seg !== ((i == 0) ? 8'h92 : 8'hC0)) begin errors++; $display("FAIL single_seg_noblank: digit %0d got %h expected %h", i, kb1.seg, (i == 0) ? 8'h92 : 8'hC0); end
        end
    endtask

    task automatic test_shift_saturate();
        bit         found;
        logic [7:0] exp_an;
        logic [3:0] exp_cnt;
        for (int v = 1; v <= 9; v++) begin
            press_start(4'(v));
            exp_cnt = (v + 1 > 8) ? 4'd8 : 4'(v + 1);
            checks++; if (kb0.digit_count !== exp_cnt) begin errors++; $display("FAIL shift_count: press %0d got %0d expected %0d", v, kb0.digit_count, exp_cnt); end
            release_key();
        end
        for (int i = 0; i < 8; i++) begin
            exp_an = ~(8'd1 << i);
            wait_an(exp_an, found);
            checks++; if (!found) begin errors++; $display("FAIL shift_scan_timeout: an %h never seen", exp_an); end
            checks++; if (kb0.seg !== hex7_tab[9 - i]) begin errors++; $display("FAIL shift_seg: digit %0d got %h expected %h", i, kb0.seg, hex7_tab[9 - i]); end
            checks++; if (kb1.seg !== hex7_tab[9 - i]) begin errors++; $display("FAIL shift_seg_noblank: digit %0d got %h expected %h", i, kb1.seg, hex7_tab[9 - i]); end
        end
    endtask

    task automatic test_hold_glitch();
        int ev;
        bit found;
        @(negedge clk);
        kb0.key_code    = 4'hA;
        kb0.key_pressed = 1'b1;
        ev = 0;
        repeat (50) begin
            @(negedge clk);
            if (kb0.key_event === 1'b1) ev++;
        end
        checks++; if (ev !== 1) begin errors++; $display("FAIL hold_events: got %0d expected 1", ev); end
        kb0.key_pressed = 1'b0;
        @(negedge clk);
        kb0.key_pressed = 1'b1;
        ev = 0;
        repeat (5) begin
            @(negedge clk);
            if (kb0.key_event === 1'b1) ev++;
        end
        checks++; if (ev !== 1) begin errors++; $display("FAIL repress_events: got %0d expected 1", ev); end
        release_key();
        checks++; if (kb0.digit_count !== 4'd8) begin errors++; $display("FAIL hold_count: got %0d expected 8", kb0.digit_count); end
        wait_an(8'hFE, found);
        checks++; if (!found || kb0.seg !== 8'h88) begin errors++; $display("FAIL hold_digit0: got %h expected 88", kb0.seg); end
        wait_an(8'hFD, found);
        checks++; if (!found || kb0.seg !== 8'h88) begin errors++; $display("FAIL hold_digit1: got %h expected 88", kb0.seg); end
        wait_an(8'hFB, found);
        checks++; if (!found || kb0.seg !== 8'h90) begin errors++; $display("FAIL hold_digit2: got %h expected 90", kb0.seg); end
        wait_an(8'h7F, found);
        checks++; if (!found || kb0.seg !== 8'h99) begin errors++; $display("FAIL hold_digit7: got %h expected 99", kb0.seg); end
    endtask

    task automatic test_clear_precedence();
        bit         found;
        logic [7:0] exp_an;
        @(negedge clk);
        kb0.key_code    = 4'h3;
        kb0.key_pressed = 1'b1;
        kb0.clr         = 1'b1;
        @(negedge clk);
        kb0.clr = 1'b0;
        checks++; if (kb0.key_event !== 1'b0) begin errors++; $display("FAIL clr_event: got %b expected 0", kb0.key_event); end
        checks++; if (kb0.digit_count !== 4'd0) begin errors++; $display("FAIL clr_count: got %0d expected 0", kb0.digit_count); end
        @(negedge clk);
        checks++; if (kb0.key_event !== 1'b0) begin errors++; $display("FAIL clr_held_event: got %b expected 0", kb0.key_event); end
        release_key();
        for (int i = 0; i < 8; i++) begin
            exp_an = ~(8'd1 << i);
            wait_an(exp_an, found);
            checks++; if (!found || kb0.seg !== 8'hFF) begin errors++; $display("FAIL clr_seg: digit %0d got %h expected ff", i, kb0.seg); end
            checks++; if (kb1.seg !== 8'hC0) begin errors++; $display("FAIL clr_seg_noblank: digit %0d got %h expected c0", i, kb1.seg); end
        end
        press_start(4'h7);
        checks++; if (kb0.digit_count !== 4'd1) begin errors++; $display("FAIL clr_reentry_count: got %0d expected 1", kb0.digit_count); end
        release_key();
        wait_an(8'hFE, found);
        checks++; if (!found || kb0.seg !== 8'hF8) begin errors++; $display("FAIL clr_reentry_digit0: got %h expected f8", kb0.seg); end
        wait_an(8'hFD, found);
        checks++; if (!found || kb1.seg !== 8'hC0) begin errors++; $display("FAIL clr_reentry_digit1_noblank: got %h expected c0", kb1.seg); end
    endtask

    task automatic test_scan_sweep();
        logic [7:0] prev;
        logic [7:0] exp_an;
        bit         found;
        found = 1'b0;
        prev  = kb0.an;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (kb0.an === 8'hFE && prev !== 8'hFE) begin
                found = 1'b1;
                break;
            end
            prev = kb0.an;
        end
        checks++; if (!found) begin errors++; $display("FAIL sweep_sync: an fe start never seen, last %h", kb0.an); end
        for (int k = 0; k < 40; k++) begin
            exp_an = ~(8'd1 << ((k / 4) % 8));
            checks++; if (kb0.an !== exp_an) begin errors++; $display("FAIL sweep_an: cycle %0d got %h expected %h", k, kb0.an, exp_an); end
            checks++; if ($countones(~kb0.an) != 1) begin errors++; $display("FAIL sweep_onehot: cycle %0d got %h expected one low bit", k, kb0.an); end
            checks++; if (kb1.an !== exp_an) begin errors++; $display("FAIL sweep_an_noblank: cycle %0d got %h expected %h", k, kb1.an, exp_an); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midscan();
        @(negedge clk);
        kb0.key_code    = 4'h4;
        kb0.key_pressed = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (kb0.an !== 8'hFF) begin errors++; $display("FAIL midscan_an: got %h expected ff", kb0.an); end
        checks++; if (kb0.seg !== 8'hFF) begin errors++; $display("FAIL midscan_seg: got %h expected ff", kb0.seg); end
        checks++; if (kb0.digit_count !== 4'd0) begin errors++; $display("FAIL midscan_count: got %0d expected 0", kb0.digit_count); end
        checks++; if (kb1.seg !== 8'hFF) begin errors++; $display("FAIL midscan_seg_noblank: got %h expected ff", kb1.seg); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (kb0.key_event !== 1'b0) begin errors++; $display("FAIL midscan_held_event: cycle %0d got %b expected 0", k, kb0.key_event); end
        end
        checks++; if (kb0.digit_count !== 4'd0) begin errors++; $display("FAIL midscan_held_count: got %0d expected 0", kb0.digit_count); end
        release_key();
    endtask

    initial begin
        kb0.key_code    = 4'h0;
        kb0.key_pressed = 1'b1;
        kb0.clr         = 1'b0;
        test_reset();
        test_single_entry();
        test_shift_saturate();
        test_hold_glitch();
        test_clear_precedence();
        test_scan_sweep();
        test_reset_midscan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_digit_display.md
Name: keypad_digit_display

Overview:
- Downstream consumer of the debounced keypad code, and replacement for the single-digit hex encoder.
- Detects each new key press and shifts the 4-bit key code into an 8-digit entry buffer; newest digit is rightmost.
- Time-multiplexes the buffer onto the 8-digit common-anode 7-segment display, driving both anode enables and segment cathodes.
- Lets the keypad act as an 8-character hex entry field instead of a one-digit echo.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays lit before the scan advances (1 kHz per digit at 100 MHz); legal range 2..2^20.
- BLANK_LEADING, 1: 1 = digit positions not yet filled are dark; 0 = unfilled positions show "0".

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- key_code  input  4  debounced key code from the debounce stage
- key_pressed  input  1  debounced level, 1 while a key is held
- clr  input  1  synchronous clear of the entry buffer, level-sensitive
- an  output  8  anode enables, active-low, one-hot-low; bit i = digit i, digit 0 is rightmost
- seg  output  8  cathodes, active-low; {dp,g,f,e,d,c,b,a}
- digit_count  output  4  number of entered digits, 0..8
- key_event  output  1  one-cycle pulse when a press is accepted

Behaviour:
- Reset (async assert, sync-safe release) sets:
  - buffer[7:0] = 0, digit_count = 0, key_event = 0
  - scan index = 0, refresh counter = 0
  - an = 8'hFF, seg = 8'hFF
  - key_q = 1, so a key held through reset release produces no event.
- Edge detect:
  - key_q registers key_pressed each cycle.
  - press_evt = key_pressed & ~key_q.
  - key_code is sampled in the press_evt cycle.
- Accepted press (press_evt & ~clr):
  - On the next edge, buffer[i] <= buffer[i-1] for i = 7..1, and buffer[0] <= key_code.
  - digit_count <= min(digit_count+1, 8).
  - key_event = 1 for exactly that one cycle; latency is 1 clk from the press_evt cycle.
- Full buffer (digit_count = 8): a further press still shifts; the oldest digit 7 is discarded and the count stays at 8.
- Holding a key produces one event only. Release followed by re-press is a new event; no minimum gap is required.
- Clear: clr = 1 sets buffer to 0 and digit_count to 0 on the next edge. If clr and press_evt occur together, clr wins and the press is discarded (key_event stays 0).
- Refresh and scan:
  - The refresh counter runs 0..REFRESH_DIV-1 and wraps.
  - When the counter reaches its terminal value, the scan index advances 0→1→…→7→0.
  - an and seg are registered and reflect the new index 1 cycle after the index changes.
  - Exactly one an bit is low at all times after the first post-reset cycle.
- Segment encoding for the digit at the scan index:
  - If BLANK_LEADING = 1 and index ≥ digit_count: seg = 8'hFF.
  - Otherwise seg = hex7(buffer[index]) with dp = 1 (off).
  - hex7, 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Buffer updates mid-scan take effect at the next registered seg update; no tearing within a cycle.
- Reset asserted mid-scan forces an = FF and seg = FF immediately (asynchronously).

Test Plan:
- Reset behaviour: assert rst_n=0 mid-scan → an=FF, seg=FF, digit_count=0 immediately. Release rst_n with key_pressed=1 held → no key_event.
- Single entry: REFRESH_DIV=4; press key 0x5 → key_event one cycle later, digit_count=1. When an=FE, seg=92. For an=FD..7F, seg=FF (BLANK_LEADING=1).
- Shift order and saturation: press 1,2,…,9 in sequence → digit_count saturates at 8. Digit7..digit0 display 2,3,4,5,6,7,8,9, so an=7F shows A4 and an=FE shows 90.
- Hold and glitch: hold key A for 50 cycles → exactly one key_event. Release 1 cycle, re-press → second event, buffer[0]=A (seg 88).
- Clear precedence: assert clr in the same cycle as press_evt of key 3 → digit_count=0, no key_event, all digits FF. With BLANK_LEADING=0, all digits C0.
- Scan sweep: REFRESH_DIV=4, run 40 cycles → an steps FE,FD,FB,F7,EF,DF,BF,7F, each for 4 cycles, then wraps to FE. Exactly one an bit is low in every cycle.
